// File: rtl/key_debounce.sv
// key_debounce
// Synchronises and debounces one mechanical push-button. Emits registered
// one-cycle press / release / long-press events, the debounced key level and
// an LED mode index that steps on every press and clears on a long press.
module key_debounce #(
    parameter int DEB_CNT        = 200000,
    parameter int LONG_CNT       = 10000000,
    parameter int KEY_ACTIVE_LOW = 1,
    parameter int MODE_NUM       = 4,
    localparam int MW            = $clog2(MODE_NUM)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          key_in,
    output logic          key_level,
    output logic          key_press,
    output logic          key_release,
    output logic          key_long,
    output logic [MW-1:0] led_mode
);

    localparam int DW = $clog2(DEB_CNT);
    localparam int HW = $clog2(LONG_CNT);

    localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CNT - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CNT - 1);
    localparam logic [MW-1:0] MODE_LAST = MW'(MODE_NUM - 1);

    // Pin level that means "not pressed"; the synchroniser is preloaded with
    // it so leaving reset never looks like a press edge.
    localparam logic REL_LEVEL = (KEY_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_FILTER_DN = 2'd1,
        S_DOWN      = 2'd2,
        S_FILTER_UP = 2'd3
    } state_t;

    state_t        state_q, state_d;

    logic          meta_q;
    logic          sync_q;
    logic          pressed;

    logic [DW-1:0] deb_q, deb_d;
    logic [HW-1:0] hold_q, hold_d;
    logic          long_done_q, long_done_d;
    logic          level_q, level_d;
    logic          press_q, press_d;
    logic          release_q, release_d;
    logic          long_q, long_d;
    logic [MW-1:0] mode_q, mode_d;

    // Two-flop synchroniser for the asynchronous pin.
    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= REL_LEVEL;
            sync_q <= REL_LEVEL;
        end else begin
            meta_q <= key_in;
            sync_q <= meta_q;
        end
    end

    // Normalise polarity so the rest of the logic works in "1 = pressed".
    assign pressed = (KEY_ACTIVE_LOW != 0) ? ~sync_q : sync_q;

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state: a level change is accepted only after DEB_CNT
    // consecutive samples at the new level; any contrary sample aborts.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE: begin
                if (pressed) begin
                    state_d = S_FILTER_DN;
                end
            end
            S_FILTER_DN: begin
                if (!pressed) begin
                    state_d = S_IDLE;
                end else if (deb_q == DEB_LAST) begin
                    state_d = S_DOWN;
                end
            end
            S_DOWN: begin
                if (!pressed) begin
                    state_d = S_FILTER_UP;
                end
            end
            S_FILTER_UP: begin
                if (pressed) begin
                    state_d = S_DOWN;
                end else if (deb_q == DEB_LAST) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // FSM outputs: counters, event pulses, debounced level and LED mode.
    // Pulses are computed here and registered below, so each lasts exactly
    // one cycle and only one can be raised per edge.
    always_comb begin
        deb_d       = deb_q;
        hold_d      = hold_q;
        long_done_d = long_done_q;
        level_d     = level_q;
        press_d     = 1'b0;
        release_d   = 1'b0;
        long_d      = 1'b0;
        mode_d      = mode_q;
        unique case (state_q)
            S_IDLE: begin
                deb_d = '0;
            end
            S_FILTER_DN: begin
                if (!pressed) begin
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    deb_d       = '0;
                    press_d     = 1'b1;
                    level_d     = 1'b1;
                    hold_d      = '0;
                    long_done_d = 1'b0;
                    mode_d      = (mode_q == MODE_LAST) ? '0 : mode_q + 1'b1;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            S_DOWN: begin
                // Hold time saturates so a very long hold cannot wrap and
                // re-trigger; long_done blocks a repeat at saturation.
                deb_d = '0;
                if (hold_q != HOLD_LAST) begin
                    hold_d = hold_q + 1'b1;
                end
                if ((hold_d == HOLD_LAST) && !long_done_q) begin
                    long_d      = 1'b1;
                    long_done_d = 1'b1;
                    mode_d      = '0;
                end
            end
            S_FILTER_UP: begin
                // Hold time is frozen while a release is being qualified, so
                // a release bounce neither extends nor resets the hold.
                if (pressed) begin
                    deb_d = '0;
                end else if (deb_q == DEB_LAST) begin
                    deb_d     = '0;
                    release_d = 1'b1;
                    level_d   = 1'b0;
                end else begin
                    deb_d = deb_q + 1'b1;
                end
            end
            default: begin
                deb_d = '0;
            end
        endcase
    end

    // Counter and output registers; reset abandons any event in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            deb_q       <= '0;
            hold_q      <= '0;
            long_done_q <= 1'b0;
            level_q     <= 1'b0;
            press_q     <= 1'b0;
            release_q   <= 1'b0;
            long_q      <= 1'b0;
            mode_q      <= '0;
        end else begin
            deb_q       <= deb_d;
            hold_q      <= hold_d;
            long_done_q <= long_done_d;
            level_q     <= level_d;
            press_q     <= press_d;
            release_q   <= release_d;
            long_q      <= long_d;
            mode_q      <= mode_d;
        end
    end

    assign key_level   = level_q;
    assign key_press   = press_q;
    assign key_release = release_q;
    assign key_long    = long_q;
    assign led_mode    = mode_q;

endmodule

// File: tb/tb_key_debounce.sv
// Testbench for key_debounce: active-low and active-high instances, with a
// scoreboard of expected events (kind, edge, mode, level).
module tb_key_debounce;

    localparam int DEB   = 4;
    localparam int LONG  = 20;
    localparam int MODES = 4;
    localparam int MW    = $clog2(MODES);

    localparam int EV_PRESS = 0;
    localparam int EV_REL   = 1;
    localparam int EV_LONG  = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          key_a, key_b;
    logic          lvl_a, prs_a, rel_a, lng_a;
    logic          lvl_b, prs_b, rel_b, lng_b;
    logic [MW-1:0] mode_a, mode_b;

    key_debounce #(
        .DEB_CNT(DEB), .LONG_CNT(LONG), .KEY_ACTIVE_LOW(1), .MODE_NUM(MODES)
    ) dut_a (
        .clk(clk), .rst(rst), .key_in(key_a),
        .key_level(lvl_a), .key_press(prs_a), .key_release(rel_a),
        .key_long(lng_a), .led_mode(mode_a)
    );

    key_debounce #(
        .DEB_CNT(DEB), .LONG_CNT(LONG), .KEY_ACTIVE_LOW(0), .MODE_NUM(MODES)
    ) dut_b (
        .clk(clk), .rst(rst), .key_in(key_b),
        .key_level(lvl_b), .key_press(prs_b), .key_release(rel_b),
        .key_long(lng_b), .led_mode(mode_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            kind;
        int            at;
        logic [MW-1:0] mode;
        logic          lvl;
    } ev_t;

    ev_t q_a[$];
    ev_t q_b[$];
    int  errors = 0;
    int  checks = 0;
    int  edge_n = 0;

    function automatic string kname(input int k);
        if (k == EV_PRESS) return "press";
        if (k == EV_REL)   return "release";
        return "long";
    endfunction

    // Expected event for instance b (0 = active-low, 1 = active-high),
    // 'dly' edges after the current one.
    task automatic expect_ev(input bit b, input int kind, input int dly,
                             input int mode, input logic lvl);
        ev_t e;
        e.kind = kind;
        e.at   = edge_n + dly;
        e.mode = MW'(mode);
        e.lvl  = lvl;
        if (b) q_b.push_back(e);
        else   q_a.push_back(e);
    endtask

    // Match observed pulses of one instance against its scoreboard queue.
    task automatic sb_drain(input bit b);
        ev_t           ev;
        logic          hit;
        logic          lv;
        logic [MW-1:0] m;
        string         nm;
        nm = b ? "dut_b" : "dut_a";
        lv = b ? lvl_b : lvl_a;
        m  = b ? mode_b : mode_a;
        while ((b ? q_b.size() : q_a.size()) > 0 &&
               (b ? q_b[0].at : q_a[0].at) < edge_n) begin
            if (b) ev = q_b.pop_front();
            else   ev = q_a.pop_front();
            checks++;
            errors++;
            $display("FAIL %s missing_%s: nothing seen, required at edge %0d",
                     nm, kname(ev.kind), ev.at);
        end
        for (int k = 0; k < 3; k++) begin
            if (b) hit = (k == EV_PRESS) ? prs_b : (k == EV_REL) ? rel_b : lng_b;
            else   hit = (k == EV_PRESS) ? prs_a : (k == EV_REL) ? rel_a : lng_a;
            if (hit === 1'b1) begin
                checks++;
                if ((b ? q_b.size() : q_a.size()) == 0) begin
                    errors++;
                    $display("FAIL %s unexpected_%s: seen at edge %0d, none required",
                             nm, kname(k), edge_n);
                end else begin
                    if (b) ev = q_b.pop_front();
                    else   ev = q_a.pop_front();
                    if (ev.kind !== k || ev.at !== edge_n || ev.mode !== m || ev.lvl !== lv) begin
                        errors++;
                        $display("FAIL %s event: got %s edge=%0d mode=%0d level=%0b, required %s edge=%0d mode=%0d level=%0b",
                                 nm, kname(k), edge_n, m, lv,
                                 kname(ev.kind), ev.at, ev.mode, ev.lvl);
                    end
                end
            end
        end
    endtask

    // Advance n clock cycles; outputs are examined on the falling edge.
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            edge_n++;
            @(negedge clk);
            sb_drain(1'b0);
            sb_drain(1'b1);
        end
    endtask

    task automatic test_reset();
        checks++;
        if ({lvl_a, prs_a, rel_a, lng_a, mode_a} !== '0) begin
            errors++;
            $display("FAIL reset_a: got lvl=%0b prs=%0b rel=%0b lng=%0b mode=%0d, required all 0",
                     lvl_a, prs_a, rel_a, lng_a, mode_a);
        end
        checks++;
        if ({lvl_b, prs_b, rel_b, lng_b, mode_b} !== '0) begin
            errors++;
            $display("FAIL reset_b: got lvl=%0b prs=%0b rel=%0b lng=%0b mode=%0d, required all 0",
                     lvl_b, prs_b, rel_b, lng_b, mode_b);
        end
        rst = 1'b0;
        step(3);
    endtask

    task automatic test_clean_press();
        key_a = 1'b0;
        expect_ev(1'b0, EV_PRESS, DEB + 3, 1, 1'b1);
        step(10);
        checks++;
        if (lvl_a !== 1'b1 || mode_a !== 2'd1) begin
            errors++;
            $display("FAIL clean_press_hold: got lvl=%0b mode=%0d, required lvl=1 mode=1", lvl_a, mode_a);
        end
        key_a = 1'b1;
        expect_ev(1'b0, EV_REL, DEB + 3, 1, 1'b0);
        step(10);
        checks++;
        if (lvl_a !== 1'b0) begin
            errors++;
            $display("FAIL clean_release_level: got %0b, required 0", lvl_a);
        end
    endtask

    task automatic test_press_bounce();
        key_a = 1'b0; step(3);
        key_a = 1'b1; step(2);
        key_a = 1'b0; step(2);
        key_a = 1'b1; step(12);
        checks++;
        if (lvl_a !== 1'b0 || mode_a !== 2'd1) begin
            errors++;
            $display("FAIL press_bounce: got lvl=%0b mode=%0d, required lvl=0 mode=1", lvl_a, mode_a);
        end
    endtask

    task automatic test_release_bounce();
        key_a = 1'b0;
        expect_ev(1'b0, EV_PRESS, DEB + 3, 2, 1'b1);
        step(10);
        key_a = 1'b1; step(2);
        key_a = 1'b0; step(3);
        checks++;
        if (lvl_a !== 1'b1) begin
            errors++;
            $display("FAIL release_bounce_level: got %0b, required 1", lvl_a);
        end
        key_a = 1'b1;
        expect_ev(1'b0, EV_REL, DEB + 3, 2, 1'b0);
        step(12);
        checks++;
        if (lvl_a !== 1'b0 || mode_a !== 2'd2) begin
            errors++;
            $display("FAIL release_bounce_end: got lvl=%0b mode=%0d, required lvl=0 mode=2", lvl_a, mode_a);
        end
    endtask

    task automatic test_mode_wrap_long();
        rst = 1'b1;
        step(1);
        checks++;
        if (mode_a !== '0) begin
            errors++;
            $display("FAIL wrap_reset_mode: got %0d, required 0", mode_a);
        end
        rst = 1'b0;
        step(2);
        for (int i = 0; i < 4; i++) begin
            key_a = 1'b0;
            expect_ev(1'b0, EV_PRESS, DEB + 3, (i + 1) % MODES, 1'b1);
            step(10);
            key_a = 1'b1;
            expect_ev(1'b0, EV_REL, DEB + 3, (i + 1) % MODES, 1'b0);
            step(10);
        end
        key_a = 1'b0;
        expect_ev(1'b0, EV_PRESS, DEB + 3, 1, 1'b1);
        expect_ev(1'b0, EV_LONG, DEB + 3 + LONG - 1, 0, 1'b1);
        step(DEB + 3 + 30);
        checks++;
        if (mode_a !== '0 || lvl_a !== 1'b1) begin
            errors++;
            $display("FAIL long_hold: got mode=%0d lvl=%0b, required mode=0 lvl=1", mode_a, lvl_a);
        end
        key_a = 1'b1;
        expect_ev(1'b0, EV_REL, DEB + 3, 0, 1'b0);
        step(12);
    endtask

    task automatic test_reset_mid_filter();
        key_a = 1'b0;
        expect_ev(1'b0, EV_PRESS, DEB + 3, 1, 1'b1);
        step(10);
        key_a = 1'b1;
        expect_ev(1'b0, EV_REL, DEB + 3, 1, 1'b0);
        step(10);
        key_a = 1'b0;
        step(4);
        rst = 1'b1;
        step(1);
        checks++;
        if ({lvl_a, prs_a, rel_a, lng_a, mode_a} !== '0) begin
            errors++;
            $display("FAIL mid_filter_reset: got lvl=%0b prs=%0b rel=%0b lng=%0b mode=%0d, required all 0",
                     lvl_a, prs_a, rel_a, lng_a, mode_a);
        end
        rst = 1'b0;
        expect_ev(1'b0, EV_PRESS, DEB + 3, 1, 1'b1);
        step(10);
        key_a = 1'b1;
        expect_ev(1'b0, EV_REL, DEB + 3, 1, 1'b0);
        step(12);
    endtask

    task automatic test_active_high();
        key_b = 1'b1;
        expect_ev(1'b1, EV_PRESS, DEB + 3, 1, 1'b1);
        step(8);
        checks++;
        if (lvl_b !== 1'b1) begin
            errors++;
            $display("FAIL active_high_level: got %0b, required 1", lvl_b);
        end
        key_b = 1'b0;
        expect_ev(1'b1, EV_REL, DEB + 3, 1, 1'b0);
        step(LONG + 5);
        checks++;
        if (lvl_b !== 1'b0 || mode_b !== 2'd1) begin
            errors++;
            $display("FAIL active_high_end: got lvl=%0b mode=%0d, required lvl=0 mode=1", lvl_b, mode_b);
        end
    endtask

    initial begin
        rst   = 1'b1;
        key_a = 1'b1;
        key_b = 1'b0;
        step(2);
        test_reset();
        test_clean_press();
        test_press_bounce();
        test_release_bounce();
        test_mode_wrap_long();
        test_reset_mid_filter();
        test_active_high();
        step(2);
        while (q_a.size() > 0) begin
            ev_t e;
            e = q_a.pop_front();
            checks++;
            errors++;
            $display("FAIL dut_a pending_%s: never seen, required at edge %0d", kname(e.kind), e.at);
        end
        while (q_b.size() > 0) begin
            ev_t e;
            e = q_b.pop_front();
            checks++;
            errors++;
            $display("FAIL dut_b pending_%s: never seen, required at edge %0d", kname(e.kind), e.at);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
